cic_interp_stream: RTL and testbench

//   Streaming CIC interpolator with valid/ready handshakes on a single clock.

---
 rtl/cic_interp_stream.sv | 96 +++++++++
 tb/tb_cic_interp_stream.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_stream.sv
// rtl/cic_interp_stream.sv - streaming CIC interpolator, combs -> zero-stuff -> integrators
module cic_interp_stream #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1,
  parameter int RATE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LR = $clog2(RATE);
  localparam int RW = WIDTH + STAGES * LR;
  localparam int SH = (STAGES - 1) * LR;
  localparam int CW = LR + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATE);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] comb_d  [STAGES];
  logic [RW-1:0] acc     [STAGES];
  logic [RW-1:0] comb_in [STAGES];
  logic [RW-1:0] integ_s [STAGES];
  logic [RW-1:0] comb_out;
  logic [RW-1:0] step_x;
  logic          last;
  logic          accept;
  logic          advance;

  assign last     = (cnt == CNT_MAX);
  assign in_ready = !rst && ((state == IDLE) || (state == EMIT && last && out_ready));
  assign accept   = in_valid && in_ready;
  assign advance  = (state == EMIT) && out_ready && !last;

  // Running locals keep each chain free of self-referencing array reads.
  always_comb begin
    logic [RW-1:0] c;
    c = {{(RW-WIDTH){1'b0}}, in_data};
    for (int k = 0; k < STAGES; k++) begin
      comb_in[k] = c;
      c = c - comb_d[k];
    end
    comb_out = c;
  end

  assign step_x = accept ? comb_out : '0;

  always_comb begin
    logic [RW-1:0] s;
    s = step_x;
    for (int k = 0; k < STAGES; k++) begin
      s = acc[k] + s;
      integ_s[k] = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        comb_d[k] <= '0;
        acc[k]    <= '0;
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < STAGES; k++) comb_d[k] <= comb_in[k];
      end
      if (accept || advance) begin
        for (int k = 0; k < STAGES; k++) acc[k] <= integ_s[k];
      end
      if (accept) begin
        state     <= EMIT;
        cnt       <= CW'(1);
        out_valid <= 1'b1;
      end else if (advance) begin
        cnt <= cnt + 1'b1;
      end else if (state == EMIT && out_ready && last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

  // Undo the R^(STAGES-1) integrator gain so DC passes at unity.
  assign out_data = acc[STAGES-1][SH +: WIDTH];

endmodule

// File: tb/tb_cic_interp_stream.sv
// tb/tb_cic_interp_stream.sv - directed bench for cic_interp_stream
module tb_cic_interp_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0] in_data_a, out_data_a;
  logic       rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [7:0] in_data_b, out_data_b;
  logic       rst_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [7:0] in_data_c, out_data_c;

  cic_interp_stream #(.WIDTH(8), .STAGES(1), .RATE(4)) u_a (
    .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a));

  cic_interp_stream #(.WIDTH(8), .STAGES(2), .RATE(2)) u_b (
    .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b));

  cic_interp_stream #(.WIDTH(8), .STAGES(3), .RATE(8)) u_c (
    .clk(clk), .rst(rst_c), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c));

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a); end
    n_tests++; if (out_data_a !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data_a); end
    n_tests++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_a); end
    n_tests++; if (out_valid_b !== 1'b0 || out_valid_c !== 1'b0) begin n_fail++; $display("FAIL reset_bc_valid: got %b%b expected 00", out_valid_b, out_valid_c); end
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    n_tests++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready_a); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [2];
    logic [7:0] got [$];
    logic [7:0] exp_v;
    int idx = 0, acc_cyc = -1, val_cyc = -1;
    vals[0] = 8'd10; vals[1] = 8'd20;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      in_valid_a  = (idx < 2);
      in_data_a   = (idx < 2) ? vals[idx] : 8'd0;
      out_ready_a = 1'b1;
      #1;
      if (out_valid_a) begin
        if (val_cyc < 0) val_cyc = c;
        got.push_back(out_data_a);
      end
      if (in_valid_a && in_ready_a) begin
        if (acc_cyc < 0) acc_cyc = c;
        idx++;
      end
    end
    in_valid_a = 1'b0;
    n_tests++; if (val_cyc != acc_cyc + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", val_cyc, acc_cyc + 1); end
    n_tests++; if (got.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_v = (i < 4) ? 8'd10 : 8'd20;
      n_tests++;
      if (i >= got.size()) begin n_fail++; $display("FAIL basic_out[%0d]: got none expected %0d", i, exp_v); end
      else if (got[i] !== exp_v) begin n_fail++; $display("FAIL basic_out[%0d]: got %0d expected %0d", i, got[i], exp_v); end
    end
    n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", out_valid_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [$];
    logic [7:0] exp_v;
    int idx = 0, gaps = 0, rdy = 0, first_rdy = -1;
    bit drained = 0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      in_valid_a  = 1'b1;
      in_data_a   = 8'(idx * 3 + 5);
      out_ready_a = 1'b1;
      #1;
      if (c >= 1) begin
        if (!out_valid_a) gaps++; else got.push_back(out_data_a);
        if (in_ready_a) begin rdy++; if (first_rdy < 0) first_rdy = c; end
      end
      if (in_valid_a && in_ready_a) idx++;
    end
    n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d expected 0", gaps); end
    n_tests++; if (rdy != 4) begin n_fail++; $display("FAIL b2b_ready_count: got %0d expected 4", rdy); end
    n_tests++; if (first_rdy != 4) begin n_fail++; $display("FAIL b2b_ready_phase: got %0d expected 4", first_rdy); end
    for (int i = 0; i < 16; i++) begin
      exp_v = 8'((i / 4) * 3 + 5);
      n_tests++;
      if (i >= got.size()) begin n_fail++; $display("FAIL b2b_out[%0d]: got none expected %0d", i, exp_v); end
      else if (got[i] !== exp_v) begin n_fail++; $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, got[i], exp_v); end
    end
    for (int c = 0; c < 12 && !drained; c++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      #1;
      if (!out_valid_a) drained = 1;
    end
    n_tests++; if (!drained) begin n_fail++; $display("FAIL b2b_drain: got busy expected idle"); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_v;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      in_valid_a  = (c <= 7);
      in_data_a   = (c == 0) ? 8'd40 : 8'd60;
      out_ready_a = !(c >= 3 && c <= 5);
      #1;
      if (c == 0) begin
        n_tests++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b expected 1", in_ready_a); end
      end else if (c <= 11) begin
        exp_v = (c <= 7) ? 8'd40 : 8'd60;
        n_tests++;
        if (out_valid_a !== 1'b1 || out_data_a !== exp_v) begin
          n_fail++; $display("FAIL bp_out[c%0d]: got v=%b d=%0d expected v=1 d=%0d", c, out_valid_a, out_data_a, exp_v);
        end
        if (c <= 7) begin
          n_tests++;
          if (in_ready_a !== (c == 7)) begin n_fail++; $display("FAIL bp_in_ready[c%0d]: got %b expected %b", c, in_ready_a, c == 7); end
        end
      end else begin
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b expected 0", out_valid_a); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      rst_a       = (c == 3);
      in_valid_a  = (c == 0 || c == 4);
      in_data_a   = (c == 0) ? 8'd30 : 8'd50;
      out_ready_a = 1'b1;
      #1;
      if (c == 3) begin
        n_tests++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_ready: got %b expected 0", in_ready_a); end
      end else if (c == 4) begin
        n_tests++;
        if (out_valid_a !== 1'b0 || out_data_a !== 8'd0 || in_ready_a !== 1'b1) begin
          n_fail++; $display("FAIL rmid_cleared: got v=%b d=%0d r=%b expected v=0 d=0 r=1", out_valid_a, out_data_a, in_ready_a);
        end
      end else if (c >= 5 && c <= 8) begin
        n_tests++;
        if (out_valid_a !== 1'b1 || out_data_a !== 8'd50) begin
          n_fail++; $display("FAIL rmid_out[c%0d]: got v=%b d=%0d expected v=1 d=50", c, out_valid_a, out_data_a);
        end
      end else if (c == 9) begin
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got %b expected 0", out_valid_a); end
      end
    end
  endtask

  task automatic test_stages2();
    logic [7:0] got [$];
    logic [7:0] exp_v;
    int idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid_b  = (idx < 3);
      in_data_b   = 8'd8;
      out_ready_b = 1'b1;
      #1;
      if (out_valid_b) got.push_back(out_data_b);
      if (in_valid_b && in_ready_b) idx++;
    end
    in_valid_b = 1'b0;
    n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL s2_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      exp_v = (i == 0) ? 8'd4 : 8'd8;
      n_tests++;
      if (i >= got.size()) begin n_fail++; $display("FAIL s2_out[%0d]: got none expected %0d", i, exp_v); end
      else if (got[i] !== exp_v) begin n_fail++; $display("FAIL s2_out[%0d]: got %0d expected %0d", i, got[i], exp_v); end
    end
  endtask

  task automatic test_settle();
    logic [7:0] got [$];
    int idx = 0, bad = 0;
    for (int c = 0; c < 54; c++) begin
      @(negedge clk);
      in_valid_c  = (idx < 6);
      in_data_c   = 8'd255;
      out_ready_c = 1'b1;
      #1;
      if (out_valid_c) got.push_back(out_data_c);
      if (in_valid_c && in_ready_c) idx++;
    end
    in_valid_c = 1'b0;
    n_tests++; if (got.size() != 48) begin n_fail++; $display("FAIL s3_count: got %0d expected 48", got.size()); end
    n_tests++;
    if (got.size() < 2) begin n_fail++; $display("FAIL s3_transient: got %0d samples expected 2", got.size()); end
    else if (got[0] !== 8'd3 || got[1] !== 8'd11) begin n_fail++; $display("FAIL s3_transient: got %0d,%0d expected 3,11", got[0], got[1]); end
    for (int i = 24; i < 48; i++) if (i >= got.size() || got[i] !== 8'd255) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL s3_settled: got %0d bad samples expected 0", bad); end
  endtask

  initial begin
    rst_a = 1'b1; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    rst_c = 1'b1; in_valid_c = 1'b0; in_data_c = '0; out_ready_c = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_stages2();
    test_settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
